// File: rtl/amds_pkt_pkg.sv
// AMDS packet receiver shared definitions: FSM state codes, byte-index codes,
// header defaults and the header-check helper.
package amds_pkt_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ARM  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [1:0] IDX_HDR = 2'd0;
   localparam logic [1:0] IDX_MSB = 2'd1;
   localparam logic [1:0] IDX_LSB = 2'd2;

   localparam logic [3:0] HDR_NIBBLE_DEF = 4'h9;
   localparam int         CHAN_W         = 3;

   // Header is good when the top nibble matches and the reserved bit 3 is 0.
   function automatic logic hdr_ok(input logic [7:0] b,
                                   input logic [3:0] nib);
      return (b[7:4] == nib) && !b[3];
   endfunction

endpackage

// File: rtl/amds_pkt_rx_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
// Ports: clk, rst_n (async, active-low), inc, count[CNT_W-1:0].
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/amds_pkt_rx.sv
// AMDS packet controller: arms the byte receiver three times per trigger
// (header, MSB, LSB), checks the header and publishes {MSB,LSB} + channel.
// Ports: clk, rst_n, sample_trig, start_rx, is_byte_valid, is_byte_corrupt,
//   is_rx_timeout, rx_byte, sample_data, sample_chan, sample_valid, busy,
//   cnt_timeout, cnt_corrupt, cnt_hdr_err, cnt_missed_trig.
// Macro AMDS_PKT_STATS_EN enables the error counters; otherwise they read 0.
module amds_pkt_rx
   import amds_pkt_pkg::*;
#(
   parameter logic [3:0] HDR_NIBBLE = HDR_NIBBLE_DEF,
   parameter int         CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_trig,
   output logic              start_rx,
   input  logic              is_byte_valid,
   input  logic              is_byte_corrupt,
   input  logic              is_rx_timeout,
   input  logic [7:0]        rx_byte,
   output logic [15:0]       sample_data,
   output logic [CHAN_W-1:0] sample_chan,
   output logic              sample_valid,
   output logic              busy,
   output logic [CNT_W-1:0]  cnt_timeout,
   output logic [CNT_W-1:0]  cnt_corrupt,
   output logic [CNT_W-1:0]  cnt_hdr_err,
   output logic [CNT_W-1:0]  cnt_missed_trig
);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [1:0]        idx;
   logic [CHAN_W-1:0] chan;
   logic [7:0]        msb;
   logic [7:0]        lsb;
   logic              take;
   logic              hdr_good;

   // A valid byte only counts when no higher-priority flag is up.
   assign take     = (state == WAIT) && !is_rx_timeout &&
                     !is_byte_corrupt && is_byte_valid;
   assign hdr_good = hdr_ok(rx_byte, HDR_NIBBLE);
   assign busy     = (state != IDLE);

   // start_rx is Mealy so the next byte is armed in the same cycle the
   // previous valid flag is seen, keeping inside the stop-bit gap.
   always_comb begin
      state_nxt = state;
      start_rx  = 1'b0;
      case (state)
         IDLE: begin
            if (sample_trig) begin
               start_rx  = 1'b1;
               state_nxt = ARM;
            end
         end
         ARM: state_nxt = WAIT;
         WAIT: begin
            if (is_rx_timeout || is_byte_corrupt) begin
               state_nxt = IDLE;
            end else if (is_byte_valid) begin
               if (idx == IDX_LSB) begin
                  state_nxt = DONE;
               end else if ((idx == IDX_MSB) || hdr_good) begin
                  start_rx  = 1'b1;
                  state_nxt = ARM;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= IDX_HDR;
         chan         <= '0;
         msb          <= '0;
         lsb          <= '0;
         sample_data  <= '0;
         sample_chan  <= '0;
         sample_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         sample_valid <= (state == DONE);
         if ((state == IDLE) && sample_trig)
            idx <= IDX_HDR;
         if (take) begin
            case (idx)
               IDX_HDR: begin
                  if (hdr_good) begin
                     chan <= rx_byte[CHAN_W-1:0];
                     idx  <= IDX_MSB;
                  end
               end
               IDX_MSB: begin
                  msb <= rx_byte;
                  idx <= IDX_LSB;
               end
               default: lsb <= rx_byte;
            endcase
         end
         if (state == DONE) begin
            sample_data <= {msb, lsb};
            sample_chan <= chan;
         end
      end
   end

`ifdef AMDS_PKT_STATS_EN
   logic ev_to;
   logic ev_co;
   logic ev_hdr;
   logic ev_miss;

   assign ev_to   = (state == WAIT) && is_rx_timeout;
   assign ev_co   = (state == WAIT) && !is_rx_timeout && is_byte_corrupt;
   assign ev_hdr  = take && (idx == IDX_HDR) && !hdr_good;
   assign ev_miss = sample_trig && (state != IDLE);

   sat_counter #(.CNT_W(CNT_W)) u_cnt_to (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ev_to),
      .count (cnt_timeout)
   );
   sat_counter #(.CNT_W(CNT_W)) u_cnt_co (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ev_co),
      .count (cnt_corrupt)
   );
   sat_counter #(.CNT_W(CNT_W)) u_cnt_hdr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ev_hdr),
      .count (cnt_hdr_err)
   );
   sat_counter #(.CNT_W(CNT_W)) u_cnt_miss (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ev_miss),
      .count (cnt_missed_trig)
   );
`else
   assign cnt_timeout     = '0;
   assign cnt_corrupt     = '0;
   assign cnt_hdr_err     = '0;
   assign cnt_missed_trig = '0;
`endif

endmodule

// File: tb/tb_amds_pkt_rx.sv
// Directed bench for amds_pkt_rx: plays the byte receiver, scoreboards
// published samples and tracks the expected error statistics.
module tb_amds_pkt_rx;

   localparam int CW  = 8;
   localparam int K_V = 0;
   localparam int K_C = 1;
   localparam int K_T = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sample_trig;
   logic          start_rx;
   logic          is_byte_valid;
   logic          is_byte_corrupt;
   logic          is_rx_timeout;
   logic [7:0]    rx_byte;
   logic [15:0]   sample_data;
   logic [2:0]    sample_chan;
   logic          sample_valid;
   logic          busy;
   logic [CW-1:0] cnt_timeout;
   logic [CW-1:0] cnt_corrupt;
   logic [CW-1:0] cnt_hdr_err;
   logic [CW-1:0] cnt_missed_trig;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int n_start = 0;
   int e_to = 0;
   int e_co = 0;
   int e_hdr = 0;
   int e_miss = 0;
   int s0;
   logic [18:0] q[$];

   amds_pkt_rx #(.CNT_W(CW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sample_trig     (sample_trig),
      .start_rx        (start_rx),
      .is_byte_valid   (is_byte_valid),
      .is_byte_corrupt (is_byte_corrupt),
      .is_rx_timeout   (is_rx_timeout),
      .rx_byte         (rx_byte),
      .sample_data     (sample_data),
      .sample_chan     (sample_chan),
      .sample_valid    (sample_valid),
      .busy            (busy),
      .cnt_timeout     (cnt_timeout),
      .cnt_corrupt     (cnt_corrupt),
      .cnt_hdr_err     (cnt_hdr_err),
      .cnt_missed_trig (cnt_missed_trig)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] ex(input int v);
`ifdef AMDS_PKT_STATS_EN
      if (v >= (1 << CW) - 1)
         return '1;
      return CW'(v);
`else
      if (v < 0)
         return '1;
      return '0;
`endif
   endfunction

   // Monitor: start pulses and published samples, mid-cycle.
   always begin
      @(negedge clk);
      #2;
      if (start_rx)
         n_start++;
      if (sample_valid) begin
         if (q.size() == 0)
            chk("sv_unexp", {31'd0, sample_valid}, 32'd0);
         else
            chk("sv_data", {13'd0, sample_chan, sample_data},
                {13'd0, q.pop_front()});
      end
   end

   task automatic chk_cnt(input string tag);
      chk({tag, "_cto"}, {24'd0, cnt_timeout}, {24'd0, ex(e_to)});
      chk({tag, "_cco"}, {24'd0, cnt_corrupt}, {24'd0, ex(e_co)});
      chk({tag, "_chd"}, {24'd0, cnt_hdr_err}, {24'd0, ex(e_hdr)});
      chk({tag, "_cmt"}, {24'd0, cnt_missed_trig}, {24'd0, ex(e_miss)});
   endtask

   task automatic trig(input string tag);
      @(negedge clk);
      sample_trig = 1'b1;
      #1 chk({tag, "_go"}, {30'd0, busy, start_rx}, 32'd1);
   endtask

   // One byte: ARM cycle with stale flags, receiver clears them, optional
   // gap (with ignored triggers), then the fresh flag.
   task automatic give(input int kind, input logic [7:0] b,
                       input logic exp_st, input int gap,
                       input int ntrig, input string tag);
      @(negedge clk);
      sample_trig = 1'b0;
      #1 chk({tag, "_arm"}, {30'd0, busy, start_rx}, 32'd2);
      @(negedge clk);
      is_byte_valid   = 1'b0;
      is_byte_corrupt = 1'b0;
      is_rx_timeout   = 1'b0;
      for (int i = 0; i < gap; i++) begin
         sample_trig = (i < ntrig);
         if (i < ntrig)
            e_miss++;
         @(negedge clk);
      end
      sample_trig     = 1'b0;
      rx_byte         = b;
      is_byte_valid   = (kind == K_V);
      is_byte_corrupt = (kind == K_C);
      is_rx_timeout   = (kind == K_T);
      #1 chk(tag, {31'd0, start_rx}, {31'd0, exp_st});
   endtask

   task automatic good(input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] l, input string tag);
      trig(tag);
      give(K_V, h, 1'b1, 1, 0, {tag, "_h"});
      give(K_V, m, 1'b1, 0, 0, {tag, "_m"});
      q.push_back({h[2:0], m, l});
      give(K_V, l, 1'b0, 2, 0, {tag, "_l"});
      @(negedge clk);
      #1 chk({tag, "_done"}, {30'd0, busy, sample_valid}, 32'd2);
      @(negedge clk);
      #1 chk({tag, "_idle"}, {30'd0, busy, sample_valid}, 32'd1);
   endtask

   initial begin
      rst_n           = 1'b0;
      sample_trig     = 1'b0;
      is_byte_valid   = 1'b0;
      is_byte_corrupt = 1'b0;
      is_rx_timeout   = 1'b0;
      rx_byte         = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ctl", {29'd0, start_rx, busy, sample_valid}, 32'd0);
      chk("rst_data", {13'd0, sample_chan, sample_data}, 32'd0);
      chk_cnt("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: good packet
      s0 = n_start;
      good(8'h93, 8'h12, 8'h34, "t1");
      chk("t1_nstart", n_start - s0, 32'd3);
      chk("t1_data", {13'd0, sample_chan, sample_data}, {13'd0, 3'd3, 16'h1234});

      // 2: timeout on MSB
      trig("t2");
      give(K_V, 8'h95, 1'b1, 0, 0, "t2_h");
      give(K_T, 8'h00, 1'b0, 3, 0, "t2_m");
      e_to++;
      @(negedge clk);
      #1 chk("t2_busy", {31'd0, busy}, 32'd0);
      chk("t2_hold", {13'd0, sample_chan, sample_data}, {13'd0, 3'd3, 16'h1234});
      chk_cnt("t2");

      // 3: header errors (bad nibble, then reserved bit set)
      s0 = n_start;
      trig("t3a");
      give(K_V, 8'hA1, 1'b0, 1, 0, "t3a_h");
      e_hdr++;
      @(negedge clk);
      #1 chk("t3a_busy", {31'd0, busy}, 32'd0);
      chk("t3a_nstart", n_start - s0, 32'd1);
      chk_cnt("t3a");
      trig("t3b");
      give(K_V, 8'h98, 1'b0, 0, 0, "t3b_h");
      e_hdr++;
      @(negedge clk);
      #1 chk("t3b_busy", {31'd0, busy}, 32'd0);
      chk_cnt("t3b");

      // 4: corrupt LSB then recovery
      trig("t4");
      give(K_V, 8'h90, 1'b1, 0, 0, "t4_h");
      give(K_V, 8'hFF, 1'b1, 1, 0, "t4_m");
      give(K_C, 8'h00, 1'b0, 0, 0, "t4_l");
      e_co++;
      @(negedge clk);
      #1 chk("t4_hold", {13'd0, sample_chan, sample_data}, {13'd0, 3'd3, 16'h1234});
      chk_cnt("t4");
      good(8'h97, 8'hAB, 8'hCD, "t4g");
      chk("t4g_data", {13'd0, sample_chan, sample_data}, {13'd0, 3'd7, 16'hABCD});

      // 5: valid flag left high from last packet across the new start_rx
      s0 = n_start;
      good(8'h96, 8'h01, 8'h02, "t5");
      chk("t5_nstart", n_start - s0, 32'd3);

      // 6: triggers while busy, including one in the DONE cycle
      trig("t6");
      give(K_V, 8'h91, 1'b1, 0, 0, "t6_h");
      give(K_V, 8'h22, 1'b1, 5, 3, "t6_m");
      q.push_back({3'd1, 16'h2233});
      give(K_V, 8'h33, 1'b0, 0, 0, "t6_l");
      @(negedge clk);
      sample_trig = 1'b1;
      e_miss++;
      #1 chk("t6_dtrig", {30'd0, busy, start_rx}, 32'd2);
      @(negedge clk);
      sample_trig = 1'b0;
      #1 chk("t6_busy", {31'd0, busy}, 32'd0);
      chk_cnt("t6");

      // saturation of the timeout counter
      for (int i = 0; i < 254; i++) begin
         trig("sat");
         give(K_T, 8'h00, 1'b0, 0, 0, "sat_t");
         e_to++;
      end
      @(negedge clk);
      #1 chk_cnt("sat1");
      for (int i = 0; i < 6; i++) begin
         trig("sat2");
         give(K_T, 8'h00, 1'b0, 0, 0, "sat2_t");
         e_to++;
      end
      @(negedge clk);
      #1 chk_cnt("sat2");

      // reset mid-WAIT
      trig("rs");
      give(K_V, 8'h92, 1'b1, 0, 0, "rs_h");
      @(negedge clk);
      @(negedge clk);
      is_byte_valid = 1'b0;
      #1 chk("rs_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      e_to = 0;
      e_co = 0;
      e_hdr = 0;
      e_miss = 0;
      #1 chk("rs_ctl", {29'd0, start_rx, busy, sample_valid}, 32'd0);
      chk("rs_data", {13'd0, sample_chan, sample_data}, 32'd0);
      chk_cnt("rs");
      @(negedge clk);
      rst_n = 1'b1;
      good(8'h94, 8'h55, 8'hAA, "rsg");
      chk("rsg_data", {13'd0, sample_chan, sample_data}, {13'd0, 3'd4, 16'h55AA});

      @(negedge clk);
      #3 chk("sb_empty", q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
